// File: rtl/riscv_decode_stage.sv
// riscv_decode_stage: decode-stage controller between fetch and execute.
// Holds up to two fetched words in a head/skid buffer behind a registered
// in_ready, decodes the immediate format of the head entry combinationally
// and drives the extended immediate together with inst/pc.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready are
// both high; valid never depends on ready, and the offering side holds its
// payload stable until the transfer completes.
//
// Optional build macro: RISCV_DECODE_PERF_EN adds the stall_cnt output, a
// free-running 32-bit count of cycles with out_valid & !out_ready.

// Immediate extender: builds the sign/zero-extended immediate for one format.
// Bits [6:0] of the instruction never contribute to an immediate, so only
// inst[31:7] is brought in.
module riscv_extend #(
    parameter int WORD_LENGTH = 32
) (
    input  logic [WORD_LENGTH-1:7] inst_hi,
    input  logic [2:0]             imm_sel,
    output logic [WORD_LENGTH-1:0] imm
);

    localparam logic [2:0] SEL_NONE = 3'd0;
    localparam logic [2:0] SEL_I    = 3'd1;
    localparam logic [2:0] SEL_S    = 3'd2;
    localparam logic [2:0] SEL_B    = 3'd3;
    localparam logic [2:0] SEL_J    = 3'd4;
    localparam logic [2:0] SEL_U    = 3'd5;
    localparam logic [2:0] SEL_Z    = 3'd6;

    // Reassemble the scattered immediate fields of the selected format.
    always_comb begin
        imm = '0;
        case (imm_sel)
            SEL_I: imm = {{20{inst_hi[31]}}, inst_hi[31:20]};
            SEL_S: imm = {{20{inst_hi[31]}}, inst_hi[31:25], inst_hi[11:7]};
            SEL_B: imm = {{19{inst_hi[31]}}, inst_hi[31], inst_hi[7],
                          inst_hi[30:25], inst_hi[11:8], 1'b0};
            SEL_J: imm = {{11{inst_hi[31]}}, inst_hi[31], inst_hi[19:12],
                          inst_hi[20], inst_hi[30:21], 1'b0};
            SEL_U: imm = {inst_hi[31:12], 12'h000};
            SEL_Z: imm = {27'd0, inst_hi[19:15]};
            SEL_NONE: imm = '0;
            default: imm = '0;
        endcase
    end

endmodule

module riscv_decode_stage #(
    parameter int WORD_LENGTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORD_LENGTH-1:0] in_inst,
    input  logic [WORD_LENGTH-1:0] in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_LENGTH-1:0] out_inst,
    output logic [WORD_LENGTH-1:0] out_pc,
    output logic [WORD_LENGTH-1:0] out_imm,
    output logic [2:0]             out_imm_sel,
    output logic                   out_illegal
`ifdef RISCV_DECODE_PERF_EN
    ,
    output logic [31:0]            stall_cnt
`endif
);

    // Buffer occupancy states.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam logic [2:0] SEL_NONE = 3'd0;
    localparam logic [2:0] SEL_I    = 3'd1;
    localparam logic [2:0] SEL_S    = 3'd2;
    localparam logic [2:0] SEL_B    = 3'd3;
    localparam logic [2:0] SEL_J    = 3'd4;
    localparam logic [2:0] SEL_U    = 3'd5;
    localparam logic [2:0] SEL_Z    = 3'd6;

    logic [1:0]             state_q, state_d;
    logic                   in_ready_q, in_ready_d;
    logic [WORD_LENGTH-1:0] head_inst_q, head_inst_d;
    logic [WORD_LENGTH-1:0] head_pc_q, head_pc_d;
    logic [WORD_LENGTH-1:0] skid_inst_q, skid_inst_d;
    logic [WORD_LENGTH-1:0] skid_pc_q, skid_pc_d;

    logic       in_fire;
    logic       out_fire;
    logic [2:0] imm_sel;
    logic       illegal;

    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = in_ready_q;
    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid & out_ready;

    // Occupancy next-state; flush overrides both handshakes.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (in_fire) state_d = ST_ONE;
                ST_ONE: begin
                    if (in_fire && !out_fire)      state_d = ST_TWO;
                    else if (out_fire && !in_fire) state_d = ST_EMPTY;
                end
                ST_TWO:   if (out_fire) state_d = ST_ONE;
                default:  state_d = ST_EMPTY;
            endcase
        end
        // Registered ready looks at where the buffer is going, not where it is.
        in_ready_d = (state_d != ST_TWO);
    end

    // Slot data movement: skid promotes to head when the head leaves in TWO.
    always_comb begin
        head_inst_d = head_inst_q;
        head_pc_d   = head_pc_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;
        if (!flush) begin
            if (out_fire) begin
                if (state_q == ST_TWO) begin
                    head_inst_d = skid_inst_q;
                    head_pc_d   = skid_pc_q;
                end else if (in_fire) begin
                    head_inst_d = in_inst;
                    head_pc_d   = in_pc;
                end
            end else if (in_fire) begin
                if (state_q == ST_EMPTY) begin
                    head_inst_d = in_inst;
                    head_pc_d   = in_pc;
                end else begin
                    skid_inst_d = in_inst;
                    skid_pc_d   = in_pc;
                end
            end
        end
    end

    // Buffer state and slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            head_inst_q <= '0;
            head_pc_q   <= '0;
            skid_inst_q <= '0;
            skid_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            head_inst_q <= head_inst_d;
            head_pc_q   <= head_pc_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
        end
    end

    // Immediate format select from the head entry's opcode.
    always_comb begin
        imm_sel = SEL_NONE;
        illegal = 1'b0;
        case (head_inst_q[6:0])
            7'b0110111, 7'b0010111:            imm_sel = SEL_U;
            7'b1101111:                        imm_sel = SEL_J;
            7'b1100111, 7'b0000011, 7'b0010011: imm_sel = SEL_I;
            7'b0100011:                        imm_sel = SEL_S;
            7'b1100011:                        imm_sel = SEL_B;
            // funct3[2] separates the uimm CSR forms from csr-address forms.
            7'b1110011:                        imm_sel = head_inst_q[14] ? SEL_Z : SEL_I;
            7'b0110011, 7'b0001111:            imm_sel = SEL_NONE;
            default:                           illegal = 1'b1;
        endcase
    end

    riscv_extend #(
        .WORD_LENGTH(WORD_LENGTH)
    ) u_extend (
        .inst_hi (head_inst_q[WORD_LENGTH-1:7]),
        .imm_sel (imm_sel),
        .imm     (out_imm)
    );

    assign out_inst    = head_inst_q;
    assign out_pc      = head_pc_q;
    assign out_imm_sel = imm_sel;
    // An empty head slot holds zero, which is not a legal opcode; only report
    // illegal for a live entry.
    assign out_illegal = out_valid & illegal;

`ifdef RISCV_DECODE_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Stall counter next value; wraps naturally, untouched by flush.
    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, (out_valid & ~out_ready)};
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Testbench for riscv_decode_stage: directed vector table, hand-written
// stall/flush/reset sequences and random traffic against a queue model.
module tb_riscv_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_imm;
    logic [2:0]  out_imm_sel;
    logic        out_illegal;
`ifdef RISCV_DECODE_PERF_EN
    logic [31:0] stall_cnt;
`endif

    // Clock
    always #5 clk = ~clk;

    riscv_decode_stage #(
        .WORD_LENGTH(32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .out_imm     (out_imm),
        .out_imm_sel (out_imm_sel),
        .out_illegal (out_illegal)
`ifdef RISCV_DECODE_PERF_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: words in flight, oldest first.
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc_q[$];
    logic        model_ready;
    logic [31:0] model_stall;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [2:0]  sel;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode from the ISA field definitions using shifts and masks.
    function automatic void ref_decode(input logic [31:0] w, output logic [2:0] sel,
                                       output logic [31:0] imm, output logic ill);
        logic signed [31:0] s;
        logic [31:0] sx;
        s   = signed'(w);
        sx  = w[31] ? 32'hFFFF_FFFF : 32'h0;
        sel = 3'd0;
        imm = 32'h0;
        ill = 1'b0;
        case (w[6:0])
            7'h37, 7'h17: begin sel = 3'd5; imm = w & 32'hFFFF_F000; end
            7'h6F: begin
                sel = 3'd4;
                imm = (sx << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
            end
            7'h67, 7'h03, 7'h13: begin sel = 3'd1; imm = s >>> 20; end
            7'h23: begin sel = 3'd2; imm = (sx << 12) | (32'(w[31:25]) << 5) | 32'(w[11:7]); end
            7'h63: begin
                sel = 3'd3;
                imm = (sx << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
            end
            7'h73: begin
                if (w[14]) begin sel = 3'd6; imm = 32'(w[19:15]); end
                else       begin sel = 3'd1; imm = s >>> 20; end
            end
            7'h33, 7'h0F: begin sel = 3'd0; imm = 32'h0; end
            default: ill = 1'b1;
        endcase
    endfunction

    // Compare every DUT output with the queue model.
    task automatic check_model();
        logic [2:0]  sel;
        logic [31:0] imm;
        logic        ill;
        chk("out_valid", out_valid, (exp_q.size() > 0));
        chk("in_ready", in_ready, model_ready);
        if (exp_q.size() > 0) begin
            ref_decode(exp_q[0], sel, imm, ill);
            chk("out_inst", out_inst, exp_q[0]);
            chk("out_pc", out_pc, exp_pc_q[0]);
            chk("out_imm_sel", out_imm_sel, sel);
            chk("out_imm", out_imm, imm);
            chk("out_illegal", out_illegal, ill);
        end
`ifdef RISCV_DECODE_PERF_EN
        chk("stall_cnt", stall_cnt, model_stall);
`endif
    endtask

    // Driver: starts at a negedge, holds inputs over one rising edge, advances
    // the model and checks at the following negedge.
    task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                        input logic ordy, input logic fl);
        logic in_fire;
        logic out_fire;
        in_valid  = v;
        in_inst   = inst;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        in_fire   = v & model_ready;
        out_fire  = (exp_q.size() > 0) & ordy;
        if ((exp_q.size() > 0) && !ordy) model_stall++;
        if (fl) begin
            exp_q.delete();
            exp_pc_q.delete();
        end else begin
            if (out_fire) begin
                void'(exp_q.pop_front());
                void'(exp_pc_q.pop_front());
            end
            if (in_fire) begin
                exp_q.push_back(inst);
                exp_pc_q.push_back(pc);
            end
        end
        model_ready = (exp_q.size() < 2);
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_pc_q.delete();
        model_ready = 1'b1;
        model_stall = 32'h0;
    endtask

    // Reset block
    task automatic reset_dut();
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = 32'h0;
        in_pc     = 32'h0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t vecs[6];
    logic [6:0] ops[12];

    initial begin
        vecs[0] = '{inst: 32'hFFF0_0093, pc: 32'h0000_0100, sel: 3'd1, imm: 32'hFFFF_FFFF, ill: 1'b0};
        vecs[1] = '{inst: 32'hFE00_0EE3, pc: 32'h0000_0104, sel: 3'd3, imm: 32'hFFFF_FFFC, ill: 1'b0};
        vecs[2] = '{inst: 32'h1234_5037, pc: 32'h0000_0108, sel: 3'd5, imm: 32'h1234_5000, ill: 1'b0};
        vecs[3] = '{inst: 32'h3400_D073, pc: 32'h0000_010C, sel: 3'd6, imm: 32'h0000_0001, ill: 1'b0};
        vecs[4] = '{inst: 32'h0000_007F, pc: 32'h0000_0110, sel: 3'd0, imm: 32'h0000_0000, ill: 1'b1};
        vecs[5] = '{inst: 32'h0020_81B3, pc: 32'h0000_0114, sel: 3'd0, imm: 32'h0000_0000, ill: 1'b0};
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h23, 7'h63, 7'h73, 7'h33, 7'h0F, 7'h7F};

        reset_dut();

        // Reset / idle state
        @(negedge clk);
        chk("rst in_ready", in_ready, 32'd1);
        chk("rst out_valid", out_valid, 32'd0);
        chk("rst out_inst", out_inst, 32'd0);
        chk("rst out_pc", out_pc, 32'd0);
        chk("rst out_imm", out_imm, 32'd0);
        chk("rst out_imm_sel", out_imm_sel, 32'd0);
        chk("rst out_illegal", out_illegal, 32'd0);
`ifdef RISCV_DECODE_PERF_EN
        chk("rst stall_cnt", stall_cnt, 32'd0);
`endif

        // Directed vector table: one word through an otherwise idle stage.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, vecs[i].inst, vecs[i].pc, 1'b1, 1'b0);
            chk("vec out_valid", out_valid, 32'd1);
            chk("vec out_pc", out_pc, vecs[i].pc);
            chk("vec out_imm_sel", out_imm_sel, vecs[i].sel);
            chk("vec out_imm", out_imm, vecs[i].imm);
            chk("vec out_illegal", out_illegal, vecs[i].ill);
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            chk("vec drained", out_valid, 32'd0);
        end

        // Back-to-back accepts while execute stalls.
        step(1'b1, 32'h8000_00EF, 32'h0000_0200, 1'b0, 1'b0);
        chk("b2b ready after 1st", in_ready, 32'd1);
        step(1'b1, 32'h00A5_A023, 32'h0000_0204, 1'b0, 1'b0);
        chk("b2b ready after 2nd", in_ready, 32'd0);
        chk("b2b jal sel", out_imm_sel, 32'd4);
        chk("b2b jal imm", out_imm, 32'hFFF0_0000);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("b2b sw sel", out_imm_sel, 32'd2);
        chk("b2b sw imm", out_imm, 32'h0000_0000);
        chk("b2b sw pc", out_pc, 32'h0000_0204);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("b2b drained", out_valid, 32'd0);

        // Flush from TWO with a word offered in the same cycle.
        step(1'b1, 32'h0010_0093, 32'h0000_0300, 1'b0, 1'b0);
        step(1'b1, 32'h0020_0113, 32'h0000_0304, 1'b0, 1'b0);
        step(1'b1, 32'h0030_0193, 32'h0000_0308, 1'b0, 1'b1);
        chk("flush out_valid", out_valid, 32'd0);
        chk("flush in_ready", in_ready, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            chk("flush no stale", out_valid, 32'd0);
        end

        // Flush coinciding with an out handshake, then resume.
        step(1'b1, 32'h0040_0213, 32'h0000_0400, 1'b0, 1'b0);
        step(1'b1, 32'h0050_0293, 32'h0000_0404, 1'b1, 1'b1);
        step(1'b1, 32'h0060_0313, 32'h0000_0408, 1'b1, 1'b0);
        chk("post-flush pc", out_pc, 32'h0000_0408);

        // Asynchronous reset with a full buffer.
        step(1'b1, 32'h0070_0393, 32'h0000_0500, 1'b0, 1'b0);
        step(1'b1, 32'h0080_0413, 32'h0000_0504, 1'b0, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid", out_valid, 32'd0);
        chk("async rst in_ready", in_ready, 32'd1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Random traffic against the queue model.
        for (int i = 0; i < 500; i++) begin
            logic [31:0] w;
            int k;
            k = $urandom_range(0, 12);
            w = $urandom;
            if (k < 12) w[6:0] = ops[k];
            step(($urandom_range(0, 9) < 7), w, $urandom, ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 15) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
